// File: rtl/data_io_unit.sv
// ---------------------------------------------------------------------------
// data_io_unit
// Data-memory and memory-mapped I/O stage of the CPU. The ALU result arrives
// as a byte address. A load from RAM takes two cycles: stall is raised for
// the first cycle, and the RAM word is returned in the second. Loads from I/O
// are combinational and never stall. Stores never stall.
//
// Ports
//   clock                in  system clock, rising edge
//   reset                in  asynchronous, active-high reset
//   addr[31:0]           in  byte address; only bits [7:2] are decoded
//   wdata[31:0]          in  store data
//   we                   in  store request
//   re                   in  load request
//   in_port0/1[31:0]     in  asynchronous external inputs
//   rdata[31:0]          out load data to the write-back mux
//   stall                out high while a RAM load has not finished
//   out_port0/1/2[31:0]  out registered output ports
// ---------------------------------------------------------------------------
module data_io_unit #(
    parameter int RAM_AW = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2
);

    typedef enum logic {IDLE, WAIT} state_t;

    // I/O word selects, taken from addr[7:2]
    localparam logic [5:0] SEL_IN0  = 6'h20;
    localparam logic [5:0] SEL_IN1  = 6'h21;
    localparam logic [5:0] SEL_OUT0 = 6'h30;
    localparam logic [5:0] SEL_OUT1 = 6'h31;
    localparam logic [5:0] SEL_OUT2 = 6'h32;
    localparam logic [5:0] SEL_CNT  = 6'h33;

    state_t             state_q, state_d;
    logic [31:0]        mem [2**RAM_AW];
    logic [31:0]        ramRdata_q;
    logic [31:0]        syncA0_q, syncB0_q, syncA1_q, syncB1_q;
    logic [31:0]        outPort0_q, outPort1_q, outPort2_q;
    logic [31:0]        cycleCnt_q, cycleCnt_d;
    logic [31:0]        ioRdata;
    logic [5:0]         ioSel;
    logic [RAM_AW-1:0]  ramAddr;
    logic               isIo;
    logic               ramWe;
    logic               ioWe;
    logic               loadStart;
    logic               unusedAddrBits;

    assign ioSel    = addr[7:2];
    assign ramAddr  = addr[RAM_AW+1:2];
    assign isIo     = addr[7];
    assign ramWe    = we && !isIo;
    assign ioWe     = we && isIo;
    // A store in the same cycle suppresses the load entirely.
    assign loadStart = (state_q == IDLE) && re && !we && !isIo;
    assign unusedAddrBits = ^{addr[31:8], addr[1:0]};

    assign out_port0 = outPort0_q;
    assign out_port1 = outPort1_q;
    assign out_port2 = outPort2_q;

    // RAM array and its read register. Kept free of reset so the array and
    // its output register can map onto a block RAM.
    always_ff @(posedge clock) begin
        if (ramWe) begin
            mem[ramAddr] <= wdata;
        end
        if (loadStart) begin
            ramRdata_q <= mem[ramAddr];
        end
    end

    // Writing the counter address clears it; the clear wins over the increment.
    always_comb begin
        cycleCnt_d = cycleCnt_q + 32'd1;
        if (ioWe && ioSel == SEL_CNT) begin
            cycleCnt_d = 32'd0;
        end
    end

    // Load FSM state, input synchronizers, output ports and cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            syncA0_q   <= 32'd0;
            syncB0_q   <= 32'd0;
            syncA1_q   <= 32'd0;
            syncB1_q   <= 32'd0;
            outPort0_q <= 32'd0;
            outPort1_q <= 32'd0;
            outPort2_q <= 32'd0;
            cycleCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            syncA0_q   <= in_port0;
            syncB0_q   <= syncA0_q;
            syncA1_q   <= in_port1;
            syncB1_q   <= syncA1_q;
            cycleCnt_q <= cycleCnt_d;
            if (ioWe && ioSel == SEL_OUT0) outPort0_q <= wdata;
            if (ioWe && ioSel == SEL_OUT1) outPort1_q <= wdata;
            if (ioWe && ioSel == SEL_OUT2) outPort2_q <= wdata;
        end
    end

    // I/O read mux; unmapped I/O addresses read as zero.
    always_comb begin
        ioRdata = 32'd0;
        case (ioSel)
            SEL_IN0:  ioRdata = syncB0_q;
            SEL_IN1:  ioRdata = syncB1_q;
            SEL_OUT0: ioRdata = outPort0_q;
            SEL_OUT1: ioRdata = outPort1_q;
            SEL_OUT2: ioRdata = outPort2_q;
            SEL_CNT:  ioRdata = cycleCnt_q;
            default:  ioRdata = 32'd0;
        endcase
    end

    // Next state and outputs. WAIT always returns to IDLE, so a load still
    // held high after completion starts a fresh two-cycle sequence. stall is
    // masked while reset is asserted, because the FSM is forced to IDLE and a
    // held re would otherwise raise it.
    always_comb begin
        state_d = state_q;
        rdata   = 32'd0;
        stall   = 1'b0;
        case (state_q)
            WAIT: begin
                rdata   = ramRdata_q;
                state_d = IDLE;
            end
            default: begin
                if (re && !we) begin
                    if (isIo) begin
                        rdata = ioRdata;
                    end else begin
                        stall   = !reset;
                        state_d = WAIT;
                    end
                end
            end
        endcase
    end

endmodule
